// File: rtl/sreg_ctrl_pkg.sv
// Shared types and constants for the serial address loader (sreg_ctrl).
package sreg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DWIDTH_DEF = 21;
  localparam int CNT_W      = $clog2(DWIDTH_DEF + 2);

  // Counter must reach DWIDTH+1 so the parity build can count its extra bit.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/sreg_ctrl_ser_shift.sv
// MSB-first serial-in shift stage with synchronous clear and shift enable.
module ser_shift #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[W-2:0], din};
  end

endmodule

// File: rtl/sreg_ctrl.sv
// Serial address loader: synchronises ser_clk/ser_din/ser_cs_n, shifts a frame
// and latches it onto addr. Define SREG_CTRL_PARITY_EN for a trailing even-parity bit.
module sreg_ctrl
  import sreg_ctrl_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_clk,
  input  logic              ser_din,
  input  logic              ser_cs_n,
  input  logic              addr_inc,
  output logic [DWIDTH-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = cnt_width(DWIDTH);
`ifdef SREG_CTRL_PARITY_EN
  localparam int FRAME_LEN = DWIDTH + 1;
`else
  localparam int FRAME_LEN = DWIDTH;
`endif

  logic [SYNC_STAGES-1:0] clk_sync, din_sync, cs_sync;
  logic                   clk_hist;
  logic                   bit_edge, bit_din, cs_n_q;

  // NOTE: the synchroniser and sample flops reset to the idle line levels
  // (clock low, select high) so no spurious edge or frame start follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '1;
      clk_hist <= 1'b0;
      bit_edge <= 1'b0;
      bit_din  <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], ser_din};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], ser_cs_n};
      clk_hist <= clk_sync[SYNC_STAGES-1];
      // Edge, data and select are registered together so they stay one aligned sample.
      bit_edge <= clk_sync[SYNC_STAGES-1] & ~clk_hist;
      bit_din  <= din_sync[SYNC_STAGES-1];
      cs_n_q   <= cs_sync[SYNC_STAGES-1];
    end
  end

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] shift_q;
  logic              sh_clr, sh_en, payload_ok;

  assign sh_clr = (state == IDLE) && !cs_n_q;
  assign sh_en  = (state == SHIFT) && !cs_n_q && bit_edge && (cnt < CW'(DWIDTH));

  ser_shift #(.W(DWIDTH)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (bit_din),
    .q     (shift_q)
  );

`ifdef SREG_CTRL_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_bit <= 1'b0;
    else if (state == SHIFT && !cs_n_q && bit_edge && cnt == CW'(DWIDTH))
      par_bit <= bit_din;
  end

  assign payload_ok = ((^shift_q) == par_bit);
`else
  assign payload_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      addr_valid <= 1'b0;
      // A frame load in LATCH takes priority over a host increment.
      if (addr_inc && state != LATCH) addr <= addr + 1'b1;

      case (state)
        IDLE: begin
          if (!cs_n_q) begin
            state     <= SHIFT;
            cnt       <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_n_q) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            busy      <= 1'b0;
          end else if (bit_edge) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(FRAME_LEN - 1)) state <= LATCH;
          end
        end
        LATCH: begin
          if (payload_ok) begin
            addr       <= shift_q;
            addr_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
          state <= DRAIN;
        end
        DRAIN: begin
          if (cs_n_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_ctrl.sv
// Scoreboard bench for sreg_ctrl: directed serial frames, queued expected loads.
module tb_sreg_ctrl;

  localparam int DW   = 21;
  localparam int SS   = 2;
  localparam int LAT  = SS + 2;
  localparam int HALF = 4;
`ifdef SREG_CTRL_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ser_clk = 1'b0;
  logic          ser_din = 1'b0;
  logic          ser_cs_n = 1'b1;
  logic          addr_inc = 1'b0;
  logic [DW-1:0] addr;
  logic          addr_valid, busy, frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sreg_ctrl #(.DWIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_clk    (ser_clk),
    .ser_din    (ser_din),
    .ser_cs_n   (ser_cs_n),
    .addr_inc   (addr_inc),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_word(input logic [DW-1:0] p);
`ifdef SREG_CTRL_PARITY_EN
    return {42'd0, p, ^p};
`else
    return {43'd0, p};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_frame();
    ser_clk  = 1'b0;
    ser_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic close_frame();
    ser_clk = 1'b0;
    tick(HALF);
    ser_cs_n = 1'b1;
    tick(8);
  endtask

  // Sends v[n-1:0] MSB first; optionally pulses addr_inc into the LATCH cycle of the last bit.
  task automatic send_bits(input logic [63:0] v, input int n, input bit inc_last);
    for (int i = n - 1; i >= 0; i--) begin
      ser_din = v[i];
      ser_clk = 1'b0;
      tick(HALF);
      ser_clk = 1'b1;
      last_rise_cyc = cyc + 1;
      if (inc_last && i == 0) begin
        tick(4);
        addr_inc = 1'b1;
        tick(1);
        addr_inc = 1'b0;
      end else begin
        tick(HALF);
      end
    end
  endtask

  // Monitor: every addr_valid pulse is matched against the scoreboard queue.
  initial begin : monitor
    logic          prev_valid;
    logic [DW-1:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (addr_valid) begin
        check("valid_single_cycle", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: addr_valid with addr %0h, expected no load", addr);
        end else begin
          e = exp_q.pop_front();
          check("load_addr", addr, e);
          check("load_latency", cyc - last_rise_cyc, LAT);
        end
      end
      prev_valid = addr_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [63:0] v;
    tick(3);
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame
    exp_q.push_back(21'h1ABCDE);
    open_frame();
    check("busy_open", busy, 1);
    send_bits(frame_word(21'h1ABCDE), FLEN, 1'b0);
    check("busy_mid", busy, 1);
    close_frame();
    check("busy_closed", busy, 0);
    check("err_clean", frame_err, 0);
    check("addr_1abcde", addr, 21'h1ABCDE);

    // Aborted frame after 10 bits
    open_frame();
    send_bits(frame_word(21'h155555) >> (FLEN - 10), 10, 1'b0);
    close_frame();
    check("abort_err", frame_err, 1);
    check("abort_addr", addr, 21'h1ABCDE);
    open_frame();
    check("err_cleared", frame_err, 0);
    exp_q.push_back(21'h1FFFFF);
    send_bits(frame_word(21'h1FFFFF), FLEN, 1'b0);
    close_frame();
    check("addr_all_ones", addr, 21'h1FFFFF);

    // Increment wraps, then increments normally
    addr_inc = 1'b1;
    tick(1);
    addr_inc = 1'b0;
    check("inc_wrap", addr, 0);
    addr_inc = 1'b1;
    tick(1);
    addr_inc = 1'b0;
    check("inc_one", addr, 1);

    // Increment coincident with LATCH is dropped
    exp_q.push_back(21'h000010);
    open_frame();
    send_bits(frame_word(21'h000010), FLEN, 1'b1);
    close_frame();
    check("inc_in_latch", addr, 21'h000010);

    // 25 clocked bits: trailing bits ignored
    exp_q.push_back(21'h0F0F0F);
    v = (frame_word(21'h0F0F0F) << (25 - FLEN)) | 64'h5;
    open_frame();
    send_bits(v, 25, 1'b0);
    close_frame();
    check("extra_addr", addr, 21'h0F0F0F);
    check("extra_err", frame_err, 0);

    // Reset mid-frame
    open_frame();
    send_bits(frame_word(21'h1AAAAA) >> (FLEN - 12), 12, 1'b0);
    rst_n    = 1'b0;
    ser_cs_n = 1'b1;
    ser_clk  = 1'b0;
    tick(2);
    check("midrst_addr", addr, 0);
    check("midrst_valid", addr_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", frame_err, 0);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back(21'h000123);
    open_frame();
    send_bits(frame_word(21'h000123), FLEN, 1'b0);
    close_frame();
    check("post_rst_addr", addr, 21'h000123);

`ifdef SREG_CTRL_PARITY_EN
    exp_q.push_back(21'h000003);
    open_frame();
    send_bits({42'd0, 21'h000003, 1'b0}, FLEN, 1'b0);
    close_frame();
    check("par_good_addr", addr, 21'h000003);
    check("par_good_err", frame_err, 0);
    open_frame();
    send_bits({42'd0, 21'h000003, 1'b1}, FLEN, 1'b0);
    close_frame();
    check("par_bad_err", frame_err, 1);
    check("par_bad_addr", addr, 21'h000003);
`endif

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
